// File: rtl/dffram_1rw1r_clr.sv
// Dual-port flip-flop RAM: one read/write port with byte enables, one read port,
// plus a sequential engine that zeroes the array after reset or on request.
module dffram_1rw1r_clr #(
  parameter int WSIZE         = 4,
  parameter int WORDS         = 128,
  parameter int INIT_ON_RESET = 1,
  localparam int AWIDTH       = $clog2(WORDS),
  localparam int DW           = WSIZE * 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CLR,
  output logic              BUSY,
  input  logic              EN0,
  input  logic [WSIZE-1:0]  WE0,
  input  logic [AWIDTH-1:0] A0,
  input  logic [DW-1:0]     Di0,
  output logic [DW-1:0]     Do0,
  input  logic              EN1,
  input  logic [AWIDTH-1:0] A1,
  output logic [DW-1:0]     Do1
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [AWIDTH-1:0] ptr;
  logic [DW-1:0]     mem [WORDS];
  logic              last;
  logic              acc;

  assign last = (ptr == AWIDTH'(WORDS - 1));
  // CLR wins over any port access presented on the same edge
  assign acc  = (state == IDLE) && !CLR;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= (INIT_ON_RESET != 0) ? CLEAR : IDLE;
      ptr   <= '0;
      Do0   <= '0;
      Do1   <= '0;
      BUSY  <= (INIT_ON_RESET != 0);
    end else begin
      unique case (state)
        IDLE: begin
          if (CLR) begin
            state <= CLEAR;
            BUSY  <= 1'b1;
            ptr   <= '0;
          end else begin
            if (EN0) Do0 <= mem[A0];
            if (EN1) Do1 <= mem[A1];
          end
        end
        CLEAR: begin
          ptr <= ptr + 1'b1;
          if (last) begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array has no reset; it is only zeroed by the clear engine
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (state == CLEAR) begin
        mem[ptr] <= '0;
      end else if (acc && EN0) begin
        for (int i = 0; i < WSIZE; i++) begin
          if (WE0[i]) mem[A0][8*i +: 8] <= Di0[8*i +: 8];
        end
      end
    end
  end

endmodule
